riego_multicanal: RTL and testbench
===================================

RIEGO_MULTICANAL -- requirements
Module: riego_multicanal

Interface
REQ-001 Parameter N_CANAL, default 4, number of pots/pump channels (2..8).
REQ-002 Parameter W_HUM, default 12, humidity sample width per channel.
REQ-003 Parameter W_T, default 8, width of time settings in seconds.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 tick1Hz  in  1  one-clk strobe once per second, synchronous to clk.
REQ-007 MODbomba  in  1  1 = pump module connected.
REQ-008 lowLevel  in  1  1 = tank water above 5 %.
REQ-009 habilitar  in  N_CANAL  per-channel enable.
REQ-010 humedad  in  N_CANAL*W_HUM  packed humidity samples; channel i at bits [i*W_HUM +: W_HUM].
REQ-011 umbral  in  N_CANAL*W_HUM  packed per-channel dryness thresholds, same packing.
REQ-012 tiempoRiego  in  W_T  watering duration per activation, seconds.
REQ-013 enfriamiento  in  W_T  per-channel cooldown after a completed watering, seconds.
REQ-014 activarB  out  N_CANAL  pump drive, one-hot or zero.
REQ-015 pendiente  out  N_CANAL  request flags (REQ-017) as currently evaluated.
REQ-016 canal  out  clog2(N_CANAL)  channel being served; alarma  out  1  tank empty while work pending.

Function
REQ-017 Channel i requests when habilitar[i]=1, humedad_i < umbral_i (strict; equal does not request) and cooldown_i = 0.
REQ-018 FSM states: IDLE, RIEGO, PAUSA, BLOQUEO.
REQ-019 IDLE: if MODbomba=1, lowLevel=1 and any request, the next clk enters RIEGO, latches the winner into canal and loads the duration counter with max(tiempoRiego,1).
REQ-020 Winner: first requesting channel scanning upward from puntero with wrap-around; puntero = last completed channel + 1 mod N_CANAL.
REQ-021 RIEGO: activarB[canal]=1; the counter decrements on each tick1Hz; on the tick that reaches 0, the next clk clears activarB, loads cooldown_canal with enfriamiento, advances puntero and enters PAUSA.
REQ-022 PAUSA: all activarB=0 until the next tick1Hz, then IDLE; guarantees at least one idle second between channels.
REQ-023 Cooldown counters run independently per channel, decrement on tick1Hz, and saturate at 0; enfriamiento=0 means no cooldown.
REQ-024 lowLevel=0 in RIEGO: the next clk clears activarB and enters BLOQUEO; the aborted channel gets no cooldown and puntero is unchanged, so it is served first afterwards.
REQ-025 BLOQUEO: activarB=0; returns to IDLE on the first tick1Hz sampled with lowLevel=1.
REQ-026 alarma = 1 whenever lowLevel=0 and any pendiente bit is 1, combinational from registered state and inputs.
REQ-027 MODbomba=0 in any state: the next clk forces IDLE with activarB=0; puntero and cooldowns are retained.
REQ-028 Input changes during RIEGO (habilitar, humedad, umbral) do not shorten a watering in progress; only lowLevel, MODbomba or rst_n abort it.
REQ-029 tick1Hz coincident with a state entry is not counted by the entered state.

Reset
REQ-030 On rst_n=0: state IDLE, activarB=0, canal=0, puntero=0, all cooldowns=0, duration counter=0, alarma driven only by REQ-026.
REQ-031 Reset asserted mid-RIEGO deasserts activarB asynchronously, with no clk edge required.

Structure
REQ-032 Shared package riego_pkg holds: the state encoding, the clog2-based width helper, and the packed-field index macros for humedad/umbral.
REQ-033 The round-robin search is the sub-module arbitro_rr (inputs req[N_CANAL] and puntero; outputs grant index and valid), purely combinational.

Verification
REQ-034 N=4, tiempoRiego=3, ch2 dry, lowLevel=1 -> activarB=4'b0100 one clk after the request, held exactly 3 ticks, then PAUSA for 1 tick, then IDLE.
REQ-035 Ch0 and ch3 both dry, enfriamiento=0, puntero=0 -> order ch0, ch3, ch0, ...; never both high at once.
REQ-036 humedad = umbral = 12'd800 on ch1 -> pendiente[1]=0 and no activation; 12'd799 -> activation.
REQ-037 lowLevel dropped during ch1 RIEGO at second 1 -> activarB=0 next clk, alarma=1, BLOQUEO; lowLevel=1 -> ch1 re-served first with a full duration.
REQ-038 enfriamiento=5, ch0 still dry after a watering -> no re-activation for 5 ticks, activation on the 6th evaluation.
REQ-039 rst_n pulsed low mid-RIEGO -> activarB=0 immediately, all counters cleared, next grant goes to channel 0 if requesting.

Source files
------------

// File: rtl/riego_pkg.sv
// Shared definitions for the multi-channel irrigation controller:
// FSM encoding, index-width helper and packed-field access macro.
`ifndef RIEGO_PKG_SV
`define RIEGO_PKG_SV

// Selects field i (width w) out of a packed per-channel bus.
`define RIEGO_CAMPO(bus, i, w) bus[(i)*(w) +: (w)]

package riego_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RIEGO   = 2'd1,
        ST_PAUSA   = 2'd2,
        ST_BLOQUEO = 2'd3
    } estado_e;

    // Width of a channel index; never zero, even for a single channel.
    function automatic int ancho_idx(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`endif

// File: rtl/arbitro_rr.sv
// Combinational round-robin search: first requesting channel at or
// after puntero, wrapping around to channel 0.
module arbitro_rr
    import riego_pkg::*;
#(
    parameter int N_CANAL = 4,
    parameter int W_IDX   = ancho_idx(N_CANAL)
) (
    input  logic [N_CANAL-1:0] req,
    input  logic [W_IDX-1:0]   puntero,
    output logic [W_IDX-1:0]   grant,
    output logic               valid
);

    logic [W_IDX-1:0] idx;

    // Scanning from the far end lets the closest requester overwrite the others.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = N_CANAL - 1; k >= 0; k--) begin
            idx = W_IDX'((int'(puntero) + k) % N_CANAL);
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/riego_multicanal.sv
// Multi-channel irrigation controller: one pump at a time, round-robin
// between dry channels, per-channel cooldown and low-tank lockout.
module riego_multicanal
    import riego_pkg::*;
#(
    parameter int N_CANAL = 4,
    parameter int W_HUM   = 12,
    parameter int W_T     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick1Hz,
    input  logic                          MODbomba,
    input  logic                          lowLevel,
    input  logic [N_CANAL-1:0]            habilitar,
    input  logic [N_CANAL*W_HUM-1:0]      humedad,
    input  logic [N_CANAL*W_HUM-1:0]      umbral,
    input  logic [W_T-1:0]                tiempoRiego,
    input  logic [W_T-1:0]                enfriamiento,
    output logic [N_CANAL-1:0]            activarB,
    output logic [N_CANAL-1:0]            pendiente,
    output logic [ancho_idx(N_CANAL)-1:0] canal,
    output logic                          alarma
);

    localparam int W_IDX = ancho_idx(N_CANAL);

    estado_e          estado_q, estado_d;
    logic [W_IDX-1:0] canal_q, canal_d;
    logic [W_IDX-1:0] puntero_q, puntero_d;
    logic [W_T-1:0]   dur_q, dur_d;
    logic [W_T-1:0]   cool_q [N_CANAL];
    logic [W_T-1:0]   cool_d [N_CANAL];
    logic [N_CANAL-1:0] req;
    logic [W_IDX-1:0] grant;
    logic             grant_valid;

    always_comb begin
        req = '0;
        for (int i = 0; i < N_CANAL; i++) begin
            req[i] = habilitar[i]
                     && (`RIEGO_CAMPO(humedad, i, W_HUM) < `RIEGO_CAMPO(umbral, i, W_HUM))
                     && (cool_q[i] == '0);
        end
    end

    arbitro_rr #(
        .N_CANAL (N_CANAL),
        .W_IDX   (W_IDX)
    ) u_arbitro (
        .req     (req),
        .puntero (puntero_q),
        .grant   (grant),
        .valid   (grant_valid)
    );

    always_comb begin
        estado_d  = estado_q;
        canal_d   = canal_q;
        puntero_d = puntero_q;
        dur_d     = dur_q;
        for (int i = 0; i < N_CANAL; i++) begin
            cool_d[i] = (tick1Hz && cool_q[i] != '0) ? cool_q[i] - W_T'(1) : cool_q[i];
        end

        if (!MODbomba) begin
            estado_d = ST_IDLE;
            dur_d    = '0;
        end else begin
            unique case (estado_q)
                ST_IDLE: begin
                    if (lowLevel && grant_valid) begin
                        estado_d = ST_RIEGO;
                        canal_d  = grant;
                        dur_d    = (tiempoRiego == '0) ? W_T'(1) : tiempoRiego;
                    end
                end
                ST_RIEGO: begin
                    // An abort keeps puntero and grants no cooldown, so this channel goes first later.
                    if (!lowLevel) begin
                        estado_d = ST_BLOQUEO;
                        dur_d    = '0;
                    end else if (tick1Hz) begin
                        if (dur_q <= W_T'(1)) begin
                            estado_d        = ST_PAUSA;
                            dur_d           = '0;
                            cool_d[canal_q] = enfriamiento;
                            puntero_d       = (canal_q == W_IDX'(N_CANAL - 1)) ? '0
                                                                               : canal_q + W_IDX'(1);
                        end else begin
                            dur_d = dur_q - W_T'(1);
                        end
                    end
                end
                ST_PAUSA: begin
                    if (tick1Hz) estado_d = ST_IDLE;
                end
                ST_BLOQUEO: begin
                    if (tick1Hz && lowLevel) estado_d = ST_IDLE;
                end
                default: estado_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments here so every flop samples the pre-edge values.
            estado_q  <= ST_IDLE;
            canal_q   <= '0;
            puntero_q <= '0;
            dur_q     <= '0;
            // NOTE: the cooldown array is real state read every cycle, so it must be reset.
            for (int i = 0; i < N_CANAL; i++) cool_q[i] <= '0;
        end else begin
            estado_q  <= estado_d;
            canal_q   <= canal_d;
            puntero_q <= puntero_d;
            dur_q     <= dur_d;
            for (int i = 0; i < N_CANAL; i++) cool_q[i] <= cool_d[i];
        end
    end

    // Decoded from the state register so an asynchronous reset drops the pump at once.
    always_comb begin
        activarB = '0;
        if (estado_q == ST_RIEGO) activarB[canal_q] = 1'b1;
    end

    assign pendiente = req;
    assign canal     = canal_q;
    assign alarma    = !lowLevel && (|req);

endmodule

// File: tb/tb_riego_multicanal.sv
// Self-checking bench for riego_multicanal: table-driven sequences plus
// hand-written corner cases, expectations queued per driven cycle.
module tb_riego_multicanal;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick1Hz;
    logic        MODbomba;
    logic        lowLevel;
    logic [3:0]  habilitar;
    logic [47:0] humedad;
    logic [47:0] umbral;
    logic [7:0]  tiempoRiego;
    logic [7:0]  enfriamiento;
    logic [3:0]  activarB;
    logic [3:0]  pendiente;
    logic [1:0]  canal;
    logic        alarma;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] act;
        logic [3:0] pend;
        logic       alarm;
        string      nm;
    } exp_t;

    typedef struct {
        bit         t;
        bit         low;
        bit         mod;
        logic [3:0] dry;
        logic [3:0] act;
        logic [3:0] pend;
        logic       alarm;
    } vec_t;

    exp_t sb[$];
    vec_t tab[$];

    riego_multicanal #(
        .N_CANAL (4),
        .W_HUM   (12),
        .W_T     (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick1Hz      (tick1Hz),
        .MODbomba     (MODbomba),
        .lowLevel     (lowLevel),
        .habilitar    (habilitar),
        .humedad      (humedad),
        .umbral       (umbral),
        .tiempoRiego  (tiempoRiego),
        .enfriamiento (enfriamiento),
        .activarB     (activarB),
        .pendiente    (pendiente),
        .canal        (canal),
        .alarma       (alarma)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, want);
        end
    endtask

    task automatic set_dry(input logic [3:0] m);
        for (int i = 0; i < 4; i++) humedad[i*12 +: 12] = m[i] ? 12'd100 : 12'd2000;
    endtask

    // One clock: drive tick, queue the expectation, compare #1 after the edge.
    task automatic step(input bit t, input logic [3:0] act, input logic [3:0] pend,
                        input logic al, input string nm);
        exp_t e;
        tick1Hz = t;
        sb.push_back('{act, pend, al, nm});
        @(posedge clk);
        #1;
        tick1Hz = 1'b0;
        e = sb.pop_front();
        check({e.nm, ".activarB"},  32'(activarB),  32'(e.act));
        check({e.nm, ".pendiente"}, 32'(pendiente), 32'(e.pend));
        check({e.nm, ".alarma"},    32'(alarma),    32'(e.alarm));
    endtask

    task automatic add(input bit t, input bit low, input bit mod, input logic [3:0] dry,
                       input logic [3:0] act, input logic [3:0] pend, input logic al);
        tab.push_back('{t, low, mod, dry, act, pend, al});
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tab.size(); i++) begin
            lowLevel = tab[i].low;
            MODbomba = tab[i].mod;
            set_dry(tab[i].dry);
            step(tab[i].t, tab[i].act, tab[i].pend, tab[i].alarm, $sformatf("%s[%0d]", tag, i));
        end
        tab.delete();
    endtask

    task automatic reset_pulse(input string nm);
        rst_n = 1'b0;
        #1;
        check({nm, ".activarB"}, 32'(activarB), 32'h0);
        check({nm, ".canal"},    32'(canal),    32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        tick1Hz      = 1'b0;
        MODbomba     = 1'b1;
        lowLevel     = 1'b1;
        habilitar    = 4'hF;
        umbral       = {4{12'd800}};
        tiempoRiego  = 8'd3;
        enfriamiento = 8'd0;
        set_dry(4'b0000);
        #2;
        check("reset.activarB",  32'(activarB),  32'h0);
        check("reset.canal",     32'(canal),     32'h0);
        check("reset.pendiente", 32'(pendiente), 32'h0);
        check("reset.alarma",    32'(alarma),    32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single dry channel 2, 3-second watering, pause, re-serve, pump unplugged.
        add(0, 1, 1, 4'b0100, 4'b0100, 4'b0100, 0);
        add(1, 1, 1, 4'b0100, 4'b0100, 4'b0100, 0);
        add(0, 1, 1, 4'b0100, 4'b0100, 4'b0100, 0);
        add(1, 1, 1, 4'b0100, 4'b0100, 4'b0100, 0);
        add(1, 1, 1, 4'b0100, 4'b0000, 4'b0100, 0);
        add(0, 1, 1, 4'b0100, 4'b0000, 4'b0100, 0);
        add(1, 1, 1, 4'b0100, 4'b0000, 4'b0100, 0);
        add(0, 1, 1, 4'b0100, 4'b0100, 4'b0100, 0);
        add(0, 1, 0, 4'b0100, 4'b0000, 4'b0100, 0);
        add(0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        run_table("single");

        reset_pulse("rst_b");

        // Channels 0 and 3 alternate; tick at RIEGO entry is not counted.
        tiempoRiego = 8'd1;
        add(0, 1, 1, 4'b1001, 4'b0001, 4'b1001, 0);
        add(1, 1, 1, 4'b1001, 4'b0000, 4'b1001, 0);
        add(1, 1, 1, 4'b1001, 4'b0000, 4'b1001, 0);
        add(1, 1, 1, 4'b1001, 4'b1000, 4'b1001, 0);
        add(1, 1, 1, 4'b1001, 4'b0000, 4'b1001, 0);
        add(1, 1, 1, 4'b1001, 4'b0000, 4'b1001, 0);
        add(0, 1, 1, 4'b1001, 4'b0001, 4'b1001, 0);
        add(1, 1, 1, 4'b1001, 4'b0000, 4'b1001, 0);
        add(1, 1, 1, 4'b1001, 4'b0000, 4'b1001, 0);
        add(0, 1, 1, 4'b1001, 4'b1000, 4'b1001, 0);
        add(0, 1, 0, 4'b1001, 4'b0000, 4'b1001, 0);
        add(0, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, 0, 1, 4'b0010, 4'b0000, 4'b0010, 1);
        add(0, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0);
        run_table("rr");

        // Equal humidity and threshold does not request; one below does.
        set_dry(4'b0000);
        humedad[12 +: 12] = 12'd800;
        step(0, 4'b0000, 4'b0000, 0, "eq800.a");
        step(0, 4'b0000, 4'b0000, 0, "eq800.b");
        humedad[12 +: 12] = 12'd799;
        step(0, 4'b0010, 4'b0010, 0, "lt799");
        check("lt799.canal", 32'(canal), 32'd1);
        step(1, 4'b0000, 4'b0000 | 4'b0010, 0, "lt799.done");
        set_dry(4'b0000);
        step(1, 4'b0000, 4'b0000, 0, "lt799.idle");

        // Tank runs low mid-watering on channel 1, then recovers with a full duration.
        tiempoRiego = 8'd3;
        set_dry(4'b0010);
        step(0, 4'b0010, 4'b0010, 0, "low.start");
        step(1, 4'b0010, 4'b0010, 0, "low.sec1");
        lowLevel = 1'b0;
        step(0, 4'b0000, 4'b0010, 1, "low.abort");
        step(1, 4'b0000, 4'b0010, 1, "low.blocked");
        lowLevel = 1'b1;
        step(0, 4'b0000, 4'b0010, 0, "low.wait_tick");
        step(1, 4'b0000, 4'b0010, 0, "low.release");
        step(0, 4'b0010, 4'b0010, 0, "low.reserve");
        check("low.canal", 32'(canal), 32'd1);
        step(1, 4'b0010, 4'b0010, 0, "low.full1");
        step(1, 4'b0010, 4'b0010, 0, "low.full2");
        step(1, 4'b0000, 4'b0010, 0, "low.full3");
        set_dry(4'b0000);
        step(1, 4'b0000, 4'b0000, 0, "low.idle");

        // Five-second cooldown on channel 0.
        tiempoRiego  = 8'd1;
        enfriamiento = 8'd5;
        set_dry(4'b0001);
        step(0, 4'b0001, 4'b0001, 0, "cool.first");
        check("cool.canal0", 32'(canal), 32'd0);
        step(1, 4'b0000, 4'b0000, 0, "cool.done");
        for (int k = 1; k <= 5; k++) begin
            step(1, 4'b0000, (k == 5) ? 4'b0001 : 4'b0000, 0, $sformatf("cool.tick%0d", k));
        end
        step(0, 4'b0001, 4'b0001, 0, "cool.again");

        // Reset in the middle of a watering on channel 2 while channel 0 is cooling.
        tiempoRiego = 8'd3;
        step(1, 4'b0000, 4'b0000, 0, "rst_mid.pausa");
        step(1, 4'b0000, 4'b0000, 0, "rst_mid.idle");
        set_dry(4'b0101);
        step(0, 4'b0100, 4'b0100, 0, "rst_mid.riego");
        check("rst_mid.canal2", 32'(canal), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid.activarB",  32'(activarB),  32'h0);
        check("rst_mid.canal",     32'(canal),     32'h0);
        check("rst_mid.pendiente", 32'(pendiente), 32'b0101);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 4'b0001, 4'b0101, 0, "rst_mid.grant0");
        check("rst_mid.grant_canal", 32'(canal), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
